// File: rtl/z3_cycle.sv
// Zorro III bus-cycle slave: synchronises FCS_n/DS_n, decodes the board base, hands address/strobes to the SDRAM controller.
// Optional data-phase watchdog is built when Z3_TIMEOUT_EN is defined.
module z3_cycle #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FCS_n,
    input  logic [3:0]  DS_n,
    input  logic        READ,
    input  logic [29:0] ADDR_IN,
    input  logic        configured,
    input  logic [3:0]  base_addr,
    input  logic        sdram_dtack,
    output logic [1:0]  z3_state,
    output logic        ram_cycle,
    output logic [25:0] ADDR,
    output logic [3:0]  DS_out_n,
    output logic        RW,
    output logic        DTACK_n,
    output logic        DOE,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, ACK = 2'd3} state_t;

    state_t                        state_q;
    logic [SYNC_STAGES-1:0]        fcs_sync_q;
    logic [SYNC_STAGES-1:0]        flush_q;
    logic [SYNC_STAGES-1:0][3:0]   ds_sync_q;
    logic                          fcs_s;
    logic [3:0]                    ds_s;
    logic                          flushed;
    logic                          armed_q;
    logic                          start_ok;
    logic                          tmo_fire;
    logic                          ram_cycle_q;
    logic                          rw_q;
    logic                          dtack_n_q;
    logic                          doe_q;
    logic [25:0]                   addr_q;
    logic [3:0]                    ds_out_q;

    // flush_q marks when the synchroniser holds real samples rather than reset ones
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fcs_sync_q <= '1;
            ds_sync_q  <= '1;
            flush_q    <= '0;
        end else begin
            fcs_sync_q[0] <= FCS_n;
            ds_sync_q[0]  <= DS_n;
            flush_q[0]    <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                fcs_sync_q[i] <= fcs_sync_q[i-1];
                ds_sync_q[i]  <= ds_sync_q[i-1];
                flush_q[i]    <= flush_q[i-1];
            end
        end
    end

    assign fcs_s   = fcs_sync_q[SYNC_STAGES-1];
    assign ds_s    = ds_sync_q[SYNC_STAGES-1];
    assign flushed = flush_q[SYNC_STAGES-1];

    // A cycle may start only on an FCS_n assertion that followed a genuinely observed high level
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            armed_q <= 1'b0;
        end else if (!flushed) begin
            armed_q <= 1'b0;
        end else if (fcs_s) begin
            armed_q <= 1'b1;
        end else if (state_q == IDLE) begin
            armed_q <= 1'b0;
        end
    end

    assign start_ok = flushed && !fcs_s && armed_q && configured && (ADDR_IN[29:26] == base_addr);

`ifdef Z3_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_err_q;
    logic             data_stay;

    assign data_stay = (state_q == DATA) && !fcs_s && !sdram_dtack;
    assign tmo_fire  = data_stay && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= tmo_fire;
            if (data_stay && !tmo_fire) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end

    assign timeout_err = tmo_err_q;
`else
    logic unused_tmo;

    assign unused_tmo  = (TIMEOUT_CYCLES > 0);
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            ram_cycle_q <= 1'b0;
            addr_q      <= '0;
            ds_out_q    <= 4'hF;
            rw_q        <= 1'b1;
            dtack_n_q   <= 1'b1;
            doe_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q     <= START;
                        ram_cycle_q <= 1'b1;
                        addr_q      <= ADDR_IN[25:0];
                        rw_q        <= READ;
                    end
                end
                START: begin
                    if (fcs_s) begin
                        state_q     <= IDLE;
                        ram_cycle_q <= 1'b0;
                        ds_out_q    <= 4'hF;
                    end else if (ds_s != 4'hF) begin
                        state_q  <= DATA;
                        ds_out_q <= ds_s;
                        doe_q    <= rw_q;
                    end
                end
                DATA: begin
                    if (fcs_s || (!sdram_dtack && tmo_fire)) begin
                        state_q     <= IDLE;
                        ram_cycle_q <= 1'b0;
                        ds_out_q    <= 4'hF;
                        doe_q       <= 1'b0;
                    end else if (sdram_dtack) begin
                        state_q   <= ACK;
                        dtack_n_q <= 1'b0;
                    end
                end
                ACK: begin
                    if (fcs_s) begin
                        state_q     <= IDLE;
                        ram_cycle_q <= 1'b0;
                        ds_out_q    <= 4'hF;
                        dtack_n_q   <= 1'b1;
                        doe_q       <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign z3_state  = state_q;
    assign ram_cycle = ram_cycle_q;
    assign ADDR      = addr_q;
    assign DS_out_n  = ds_out_q;
    assign RW        = rw_q;
    assign DTACK_n   = dtack_n_q;
    assign DOE       = doe_q;

endmodule

// File: tb/tb_z3_cycle.sv
// Self-checking bench for z3_cycle: vector table of bus cycles, scoreboard checked on each DTACK_n assertion,
// plus hand-written abort, back-to-back, reset-in-ACK and (with Z3_TIMEOUT_EN) watchdog sequences.
module tb_z3_cycle;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FCS_n;
    logic [3:0]  DS_n;
    logic        READ;
    logic [29:0] ADDR_IN;
    logic        configured;
    logic [3:0]  base_addr;
    logic        sdram_dtack;
    logic [1:0]  z3_state;
    logic        ram_cycle;
    logic [25:0] ADDR;
    logic [3:0]  DS_out_n;
    logic        RW;
    logic        DTACK_n;
    logic        DOE;
    logic        timeout_err;

    z3_cycle #(.TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .FCS_n(FCS_n), .DS_n(DS_n), .READ(READ),
        .ADDR_IN(ADDR_IN), .configured(configured), .base_addr(base_addr),
        .sdram_dtack(sdram_dtack), .z3_state(z3_state), .ram_cycle(ram_cycle),
        .ADDR(ADDR), .DS_out_n(DS_out_n), .RW(RW), .DTACK_n(DTACK_n), .DOE(DOE),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic        read;
        logic [3:0]  ds;
        logic        cfg;
        logic [3:0]  base;
        int          dly;
        logic        exp_match;
        logic [25:0] exp_addr;
        logic [3:0]  exp_ds;
        logic        exp_doe;
    } vec_t;

    typedef struct {
        logic [25:0] addr;
        logic [3:0]  ds;
        logic        rw;
    } exp_t;

    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_ACK = 2'd3;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    logic doe_seen = 1'b0;
    logic dtack_seen = 1'b0;
    int   tmo_pulses = 0;
    logic dtack_prev = 1'b1;
    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            if (z3_state == s) ok = 1'b1;
        end
        if (!ok) chk(name, 32'(z3_state), 32'(s));
    endtask

    // Scoreboard: pop one expected transfer whenever DTACK_n falls
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (DOE) doe_seen = 1'b1;
                if (!DTACK_n) dtack_seen = 1'b1;
                if (timeout_err) tmo_pulses++;
                if (dtack_prev && !DTACK_n) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_ack: DTACK_n asserted with addr %0h, no transfer expected", ADDR);
                    end else begin
                        e = sbq.pop_front();
                        chk("ack_addr", 32'(ADDR), 32'(e.addr));
                        chk("ack_ds", 32'(DS_out_n), 32'(e.ds));
                        chk("ack_rw", 32'(RW), 32'(e.rw));
                    end
                end
            end
            dtack_prev = DTACK_n;
        end
    end

    task automatic run_vec(input vec_t v);
        logic bad = 1'b0;
        ADDR_IN = v.addr[31:2]; READ = v.read; configured = v.cfg; base_addr = v.base;
        DS_n = 4'hF; sdram_dtack = 1'b0;
        tick();
        doe_seen = 1'b0; dtack_seen = 1'b0;
        if (v.exp_match) sbq.push_back('{v.exp_addr, v.exp_ds, v.read});
        FCS_n = 1'b0;
        tick(); tick();
        chk("lat_idle", 32'(z3_state), 32'(S_IDLE));
        tick();
        chk("lat_start", 32'(z3_state), v.exp_match ? 32'(S_START) : 32'(S_IDLE));
        chk("start_ram_cycle", 32'(ram_cycle), 32'(v.exp_match));
        DS_n = v.ds;
        if (v.exp_match) begin
            wait_state(S_DATA, 6, "reach_data");
            repeat (v.dly) tick();
            sdram_dtack = 1'b1;
            wait_state(S_ACK, 6, "reach_ack");
            sdram_dtack = 1'b0;
            chk("ack_dtack_n", 32'(DTACK_n), 32'd0);
            chk("ack_doe", 32'(DOE), 32'(v.exp_doe));
        end else begin
            sdram_dtack = 1'b1;
            repeat (8) begin
                tick();
                bad = bad | (z3_state != S_IDLE) | ram_cycle | ~DTACK_n | DOE;
            end
            chk("nomatch_quiet", 32'(bad), 32'd0);
        end
        FCS_n = 1'b1; DS_n = 4'hF; sdram_dtack = 1'b0;
        wait_state(S_IDLE, 6, "reach_idle");
        tick();
        chk("idle_dtack_n", 32'(DTACK_n), 32'd1);
        chk("idle_ram_cycle", 32'(ram_cycle), 32'd0);
        chk("idle_ds_out", 32'(DS_out_n), 32'hF);
        chk("cycle_doe_seen", 32'(doe_seen), 32'(v.exp_doe));
        chk("cycle_dtack_seen", 32'(dtack_seen), 32'(v.exp_match));
        repeat (3) tick();
    endtask

    initial begin
        logic bad;
        // addr, read, ds, cfg, base, dly, match, exp_addr, exp_ds, exp_doe
        vt[0] = '{32'h4000_0100, 1'b1, 4'b0000, 1'b1, 4'h4, 5, 1'b1, 26'h40,      4'b0000, 1'b1};
        vt[1] = '{32'h5000_0000, 1'b1, 4'b0000, 1'b1, 4'h4, 0, 1'b0, 26'h0,       4'hF,    1'b0};
        vt[2] = '{32'h4ABC_DEF8, 1'b0, 4'b1100, 1'b1, 4'h4, 2, 1'b1, 26'h2AF37BE, 4'b1100, 1'b0};
        vt[3] = '{32'h4000_0000, 1'b1, 4'b0000, 1'b0, 4'h4, 0, 1'b0, 26'h0,       4'hF,    1'b0};
        vt[4] = '{32'hFFFF_FFFC, 1'b1, 4'b0101, 1'b1, 4'hF, 0, 1'b1, 26'h3FFFFFF, 4'b0101, 1'b1};
        vt[5] = '{32'h0000_0004, 1'b0, 4'b0111, 1'b1, 4'h0, 1, 1'b1, 26'h1,       4'b0111, 1'b0};

        RESET = 1'b1; FCS_n = 1'b1; DS_n = 4'hF; READ = 1'b1; ADDR_IN = '0;
        configured = 1'b1; base_addr = 4'h4; sdram_dtack = 1'b0;
        repeat (3) tick();
        chk("rst_state", 32'(z3_state), 32'(S_IDLE));
        chk("rst_ram_cycle", 32'(ram_cycle), 32'd0);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_ds_out", 32'(DS_out_n), 32'hF);
        chk("rst_rw", 32'(RW), 32'd1);
        chk("rst_dtack_n", 32'(DTACK_n), 32'd1);
        chk("rst_doe", 32'(DOE), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        RESET = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Abort: FCS_n released in START without any data strobe
        ADDR_IN = vt[0].addr[31:2]; READ = 1'b1; base_addr = 4'h4; configured = 1'b1;
        dtack_seen = 1'b0;
        FCS_n = 1'b0;
        wait_state(S_START, 6, "abort_reach_start");
        repeat (3) tick();
        chk("abort_hold_start", 32'(z3_state), 32'(S_START));
        FCS_n = 1'b1;
        wait_state(S_IDLE, 6, "abort_idle");
        chk("abort_ram_cycle", 32'(ram_cycle), 32'd0);
        chk("abort_dtack_seen", 32'(dtack_seen), 32'd0);
        repeat (3) tick();

        // Back-to-back: FCS_n high for a single clock after ACK restarts at once
        sbq.push_back('{26'h40, 4'b0000, 1'b1});
        FCS_n = 1'b0; DS_n = 4'b0000;
        wait_state(S_DATA, 8, "b2b_reach_data");
        sdram_dtack = 1'b1;
        wait_state(S_ACK, 4, "b2b_reach_ack");
        sdram_dtack = 1'b0;
        sbq.push_back('{26'h80, 4'b0000, 1'b1});
        FCS_n = 1'b1; ADDR_IN = 30'h1000_0080;
        tick();
        FCS_n = 1'b0;
        wait_state(S_IDLE, 4, "b2b_idle");
        tick();
        chk("b2b_restart", 32'(z3_state), 32'(S_START));
        wait_state(S_DATA, 6, "b2b2_reach_data");
        sdram_dtack = 1'b1;
        wait_state(S_ACK, 4, "b2b2_reach_ack");
        sdram_dtack = 1'b0;
        FCS_n = 1'b1; DS_n = 4'hF;
        wait_state(S_IDLE, 6, "b2b2_idle");
        repeat (3) tick();

        // Reset asserted in ACK with FCS_n held low
        ADDR_IN = vt[0].addr[31:2];
        sbq.push_back('{26'h40, 4'b0000, 1'b1});
        FCS_n = 1'b0; DS_n = 4'b0000;
        wait_state(S_DATA, 8, "rstack_reach_data");
        sdram_dtack = 1'b1;
        wait_state(S_ACK, 4, "rstack_reach_ack");
        sdram_dtack = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk("rstack_dtack_n", 32'(DTACK_n), 32'd1);
        chk("rstack_state", 32'(z3_state), 32'(S_IDLE));
        chk("rstack_ram_cycle", 32'(ram_cycle), 32'd0);
        chk("rstack_ds_out", 32'(DS_out_n), 32'hF);
        tick(); tick();
        RESET = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            tick();
            bad = bad | (z3_state != S_IDLE) | ram_cycle;
        end
        chk("rstack_ignore_low_fcs", 32'(bad), 32'd0);
        FCS_n = 1'b1; DS_n = 4'hF;
        repeat (4) tick();
        sbq.push_back('{26'h40, 4'b0011, 1'b1});
        FCS_n = 1'b0;
        wait_state(S_START, 4, "rstack_new_start");
        DS_n = 4'b0011;
        wait_state(S_DATA, 6, "rstack_new_data");
        sdram_dtack = 1'b1;
        wait_state(S_ACK, 4, "rstack_new_ack");
        sdram_dtack = 1'b0;
        FCS_n = 1'b1; DS_n = 4'hF;
        wait_state(S_IDLE, 6, "rstack_new_idle");
        repeat (3) tick();

`ifdef Z3_TIMEOUT_EN
        begin
            int data_n;
            tmo_pulses = 0;
            FCS_n = 1'b0; DS_n = 4'b0000; sdram_dtack = 1'b0;
            wait_state(S_DATA, 8, "tmo_reach_data");
            data_n = 1;
            repeat (80) begin
                tick();
                if (z3_state == S_DATA) data_n++;
            end
            chk("tmo_data_cycles", 32'(data_n), 32'd64);
            chk("tmo_pulses", 32'(tmo_pulses), 32'd1);
            chk("tmo_state", 32'(z3_state), 32'(S_IDLE));
            chk("tmo_ram_cycle", 32'(ram_cycle), 32'd0);
            FCS_n = 1'b1; DS_n = 4'hF;
            repeat (4) tick();
        end
`else
        chk("timeout_err_never", 32'(tmo_pulses), 32'd0);
`endif

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/z3_cycle.md
Z3_CYCLE -- requirements
Module: z3_cycle

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, data-phase watchdog limit in CLK cycles (used only with Z3_TIMEOUT_EN).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for FCS_n and DS_n.
REQ-003 CLK  input  1  board clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 FCS_n  input  1  Zorro III full cycle strobe; asynchronous to CLK.
REQ-006 DS_n  input  4  Zorro III data strobes; asynchronous to CLK.
REQ-007 READ  input  1  bus direction; 1 = read.
REQ-008 ADDR_IN  input  30  [31:2] output of the external address latch; stable while FCS_n low.
REQ-009 configured  input  1  autoconfig complete.
REQ-010 base_addr  input  4  assigned base, compared against ADDR_IN[31:28].
REQ-011 sdram_dtack  input  1  data-ready from the SDRAM controller.
REQ-012 z3_state  output  2  cycle phase: IDLE=0, START=1, DATA=2, ACK=3.
REQ-013 ram_cycle  output  1  current cycle targets this board.
REQ-014 ADDR  output  26  [27:2] registered address for the SDRAM controller.
REQ-015 DS_out_n  output  4  registered data strobes for the SDRAM controller.
REQ-016 RW  output  1  registered READ.
REQ-017 DTACK_n  output  1  bus data acknowledge; low = asserted.
REQ-018 DOE  output  1  data buffer output enable toward the bus.
REQ-019 timeout_err  output  1  single-cycle watchdog pulse.

Function
REQ-020 FCS_n and each DS_n bit SHALL pass through SYNC_STAGES flops; fcs_s/ds_s denote the final stage.
REQ-021 IDLE: on fcs_s low with configured=1 and ADDR_IN[31:28]==base_addr, SHALL register ADDR, RW and ram_cycle=1 and enter START on the same edge.
REQ-022 IDLE with fcs_s low and no match SHALL remain IDLE with ram_cycle=0, DTACK_n=1 and DOE=0 until fcs_s returns high; it SHALL NOT re-evaluate the match within that cycle.
REQ-023 START: any ds_s bit low SHALL register DS_out_n=ds_s and enter DATA; fcs_s high SHALL enter IDLE and clear ram_cycle (abort).
REQ-024 DATA: sdram_dtack=1 SHALL enter ACK and drive DTACK_n=0 on the same edge; fcs_s high SHALL enter IDLE and clear ram_cycle.
REQ-025 ACK: SHALL hold DTACK_n=0 until fcs_s is high, then enter IDLE with DTACK_n=1, ram_cycle=0 and DS_out_n=4'hF.
REQ-026 DOE SHALL be 1 only when RW=1, ram_cycle=1 and z3_state is DATA or ACK.
REQ-027 Latency: FCS_n falling before CLK edge k SHALL yield z3_state=START at edge k+SYNC_STAGES.
REQ-028 Encoding SHALL keep START < DATA < ACK numerically; the SDRAM controller compares with >=.
REQ-029 Back-to-back cycles: fcs_s low on the IDLE edge that follows ACK SHALL start a new cycle with no extra idle cycle.

Reset
REQ-030 RESET high SHALL asynchronously force z3_state=IDLE, ram_cycle=0, ADDR=0, DS_out_n=4'hF, RW=1, DTACK_n=1, DOE=0, timeout_err=0, and set all synchroniser flops to 1.
REQ-031 Reset during any state SHALL abandon the cycle; after release, an FCS_n already low SHALL be ignored until it has been seen high once.

Configuration
REQ-032 Macro Z3_TIMEOUT_EN defined: a counter SHALL count cycles spent in DATA; on reaching TIMEOUT_CYCLES it SHALL pulse timeout_err for one cycle, force IDLE and clear ram_cycle. The counter SHALL clear on leaving DATA.
REQ-033 Z3_TIMEOUT_EN undefined: no counter is built, timeout_err SHALL be tied 0, and DATA is left only by sdram_dtack or FCS release.

Verification
REQ-034 Matching read: base_addr=4'h4, ADDR_IN=32'h4000_0100, READ=1, FCS_n low, DS_n=0, sdram_dtack at +5 -> START at k+2, DATA, DTACK_n=0, DOE=1, ADDR=26'h40, IDLE after FCS_n high.
REQ-035 Non-match: ADDR_IN=32'h5000_0000 -> z3_state stays 0, ram_cycle=0, DTACK_n=1 for the whole cycle.
REQ-036 Abort: FCS_n released in START with no DS_n -> IDLE, ram_cycle=0, DTACK_n never asserted.
REQ-037 Write with DS_n=4'b1100 -> DS_out_n=4'b1100, RW=0, DOE=0 throughout.
REQ-038 Z3_TIMEOUT_EN, TIMEOUT_CYCLES=64, sdram_dtack held 0 -> timeout_err pulses exactly once after 64 DATA cycles, then IDLE.
REQ-039 RESET pulsed in ACK while FCS_n stays low -> DTACK_n=1 immediately; no new cycle until FCS_n has gone high and then low again.
